// File: rtl/proximity_pkg.sv
// Shared definitions for the proximity scan controller: FSM encoding,
// default timing parameters and a counter-width helper.
package proximity_pkg;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_WAIT_PERIOD = 3'd1,
        ST_SETTLE      = 3'd2,
        ST_SAMPLE      = 3'd3,
        ST_DECIDE      = 3'd4,
        ST_REPORT      = 3'd5
    } state_t;

    localparam int DEF_SETTLE_CYC = 16;
    localparam int DEF_SAMPLES    = 8;
    localparam int DEF_PERIOD_CYC = 12000;

    // Width of a counter that runs 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for one asynchronous input bit; clears to 0 on reset.
module sync2 (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta <= 1'b0;
            r_q    <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_q    <= r_meta;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/proximity_scan_ctrl.sv
// Round-robin proximity sensor scanner: enables one sensor at a time, majority-votes
// its samples and reports debounced state changes over a valid/ready event port.
module proximity_scan_ctrl
    import proximity_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int SETTLE_CYC = DEF_SETTLE_CYC,
    parameter int SAMPLES    = DEF_SAMPLES,
    parameter int PERIOD_CYC = DEF_PERIOD_CYC
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [NUM_CH-1:0]         pin,
    output logic [NUM_CH-1:0]         sensor_en,
    output logic                      evt_valid,
    input  logic                      evt_ready,
    output logic [$clog2(NUM_CH)-1:0] evt_ch,
    output logic                      evt_present,
    output logic [NUM_CH-1:0]         present,
    output logic                      busy,
    output state_t                    o_dbg_state,
    output logic [$clog2(NUM_CH)-1:0] o_dbg_ch
);

    localparam int CH_W   = $clog2(NUM_CH);
    localparam int SET_W  = cnt_width(SETTLE_CYC);
    localparam int SMP_W  = $clog2(SAMPLES);
    localparam int ONES_W = $clog2(SAMPLES) + 1;
    localparam int PER_W  = cnt_width(PERIOD_CYC);

    localparam logic [CH_W-1:0]   LAST_CH  = CH_W'(NUM_CH - 1);
    localparam logic [SET_W-1:0]  SET_LAST = SET_W'(SETTLE_CYC - 1);
    localparam logic [SMP_W-1:0]  SMP_LAST = SMP_W'(SAMPLES - 1);
    localparam logic [PER_W-1:0]  PER_LAST = PER_W'(PERIOD_CYC - 1);
    localparam logic [ONES_W-1:0] HALF     = ONES_W'(SAMPLES / 2);

    state_t              r_state;
    state_t              w_next;
    logic [CH_W-1:0]     r_ch;
    logic [SET_W-1:0]    r_set_cnt;
    logic [SMP_W-1:0]    r_smp_cnt;
    logic [ONES_W-1:0]   r_ones;
    logic [PER_W-1:0]    r_per_cnt;
    logic [NUM_CH-1:0]   r_present;
    logic [CH_W-1:0]     r_evt_ch;
    logic                r_evt_present;

    logic [NUM_CH-1:0]   w_pin_sync;
    logic                w_sample;
    logic                w_new;
    logic                w_change;
    logic                w_last_ch;
    logic                w_advance;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_sync
        sync2 u_sync (
            .i_clk (clk),
            .i_rst (rst),
            .i_d   (pin[g]),
            .o_q   (w_pin_sync[g])
        );
    end

    assign w_sample  = w_pin_sync[r_ch];
    assign w_last_ch = (r_ch == LAST_CH);

    // Majority vote; an exact tie keeps the channel's previous state.
    always_comb begin
        w_new = r_present[r_ch];
        if (r_ones > HALF) begin
            w_new = 1'b1;
        end else if (r_ones < HALF) begin
            w_new = 1'b0;
        end
    end

    assign w_change  = (w_new != r_present[r_ch]);
    assign w_advance = ((r_state == ST_DECIDE) && !w_change) ||
                       ((r_state == ST_REPORT) && evt_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (start) w_next = ST_SETTLE;
            end
            ST_WAIT_PERIOD: begin
                if (!start) begin
                    w_next = ST_IDLE;
                end else if (r_per_cnt == PER_LAST) begin
                    w_next = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (r_set_cnt == SET_LAST) w_next = ST_SAMPLE;
            end
            ST_SAMPLE: begin
                if (r_smp_cnt == SMP_LAST) w_next = ST_DECIDE;
            end
            ST_DECIDE: begin
                if (w_change) begin
                    w_next = ST_REPORT;
                end else begin
                    w_next = w_last_ch ? ST_WAIT_PERIOD : ST_SETTLE;
                end
            end
            ST_REPORT: begin
                if (evt_ready) w_next = w_last_ch ? ST_WAIT_PERIOD : ST_SETTLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Counters stay at zero outside their own state, so each entry starts from 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ch          <= '0;
            r_set_cnt     <= '0;
            r_smp_cnt     <= '0;
            r_ones        <= '0;
            r_per_cnt     <= '0;
            r_present     <= '0;
            r_evt_ch      <= '0;
            r_evt_present <= 1'b0;
        end else begin
            r_set_cnt <= ((r_state == ST_SETTLE) && (r_set_cnt != SET_LAST)) ?
                         r_set_cnt + SET_W'(1) : '0;
            r_smp_cnt <= ((r_state == ST_SAMPLE) && (r_smp_cnt != SMP_LAST)) ?
                         r_smp_cnt + SMP_W'(1) : '0;
            r_per_cnt <= ((r_state == ST_WAIT_PERIOD) && (r_per_cnt != PER_LAST)) ?
                         r_per_cnt + PER_W'(1) : '0;

            if (r_state == ST_SETTLE) begin
                r_ones <= '0;
            end else if (r_state == ST_SAMPLE) begin
                r_ones <= r_ones + ONES_W'(w_sample);
            end

            if ((r_state == ST_DECIDE) && w_change) begin
                r_present[r_ch] <= w_new;
                r_evt_ch        <= r_ch;
                r_evt_present   <= w_new;
            end

            if (w_advance) begin
                r_ch <= w_last_ch ? '0 : r_ch + CH_W'(1);
            end
        end
    end

    always_comb begin
        sensor_en = '0;
        if ((r_state == ST_SETTLE) || (r_state == ST_SAMPLE)) begin
            sensor_en[r_ch] = 1'b1;
        end
        evt_valid = (r_state == ST_REPORT);
        busy      = (r_state != ST_IDLE);
    end

    assign evt_ch      = r_evt_ch;
    assign evt_present = r_evt_present;
    assign present     = r_present;
    assign o_dbg_state = r_state;
    assign o_dbg_ch    = r_ch;

endmodule

// File: tb/tb_proximity_scan_ctrl.sv
// Directed bench for proximity_scan_ctrl: per-round vector table plus
// hand-written back-pressure, stop/wrap and reset-during-report sequences.
module tb_proximity_scan_ctrl;
    import proximity_pkg::*;

    localparam int NUM_CH     = 4;
    localparam int SETTLE_CYC = 4;
    localparam int SAMPLES    = 8;
    localparam int PERIOD_CYC = 20;
    localparam int CH_W       = 2;
    localparam int W          = CH_W + 1;
    localparam int NVEC       = 7;
    // Pin value driven on the n-th enabled negedge reaches sample n-LEAD.
    localparam int LEAD       = SETTLE_CYC - 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              evt_ready = 1'b1;
    logic [NUM_CH-1:0] pin;
    logic [NUM_CH-1:0] sensor_en;
    logic              evt_valid;
    logic [CH_W-1:0]   evt_ch;
    logic              evt_present;
    logic [NUM_CH-1:0] present;
    logic              busy;
    state_t            dbg_state;
    logic [CH_W-1:0]   dbg_ch;

    typedef struct {
        logic [7:0]        pat [NUM_CH];
        logic [NUM_CH-1:0] exp_present;
        logic [NUM_CH-1:0] exp_evt_mask;
    } round_vec_t;

    round_vec_t vecs [NVEC];
    logic [7:0] sens_pat [NUM_CH];
    logic [W-1:0] exp_q[$];
    int n_checks = 0;
    int n_pass = 0;
    int onehot_viol = 0;

    proximity_scan_ctrl #(
        .NUM_CH     (NUM_CH),
        .SETTLE_CYC (SETTLE_CYC),
        .SAMPLES    (SAMPLES),
        .PERIOD_CYC (PERIOD_CYC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .pin         (pin),
        .sensor_en   (sensor_en),
        .evt_valid   (evt_valid),
        .evt_ready   (evt_ready),
        .evt_ch      (evt_ch),
        .evt_present (evt_present),
        .present     (present),
        .busy        (busy),
        .o_dbg_state (dbg_state),
        .o_dbg_ch    (dbg_ch)
    );

    initial begin
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, required $finish before it");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_state(input state_t s, input int bound, input string name);
        int k = 0;
        while (dbg_state != s && k < bound) begin
            tick();
            k++;
        end
        check(name, dbg_state, s);
    endtask

    task automatic wait_evt_valid(input int bound, input string name);
        int k = 0;
        while (!evt_valid && k < bound) begin
            tick();
            k++;
        end
        check(name, evt_valid, 1);
    endtask

    task automatic load_round(input int i);
        for (int c = 0; c < NUM_CH; c++) begin
            sens_pat[c] = vecs[i].pat[c];
            if (vecs[i].exp_evt_mask[c]) begin
                exp_q.push_back({CH_W'(c), vecs[i].exp_present[c]});
            end
        end
    endtask

    // Sensor model, event scoreboard and continuous enable check, all at negedge.
    initial begin : sensor_and_monitor
        int n [NUM_CH];
        logic [W-1:0] got;
        logic [W-1:0] want;
        for (int c = 0; c < NUM_CH; c++) begin
            n[c] = 0;
            sens_pat[c] = 8'h00;
        end
        pin = '0;
        forever begin
            @(negedge clk);
            if (!$onehot0(sensor_en)) onehot_viol++;
            if (sensor_en != '0 && dbg_state != ST_SETTLE && dbg_state != ST_SAMPLE) onehot_viol++;
            if (evt_valid && evt_ready) begin
                got = {evt_ch, evt_present};
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_event: got ch=%0d present=%0d, required no event", evt_ch, evt_present);
                end else begin
                    want = exp_q.pop_front();
                    check("event", got, want);
                end
            end
            for (int c = 0; c < NUM_CH; c++) begin
                if (sensor_en[c]) begin
                    pin[c] = (n[c] >= LEAD && n[c] < LEAD + SAMPLES) ? sens_pat[c][n[c] - LEAD] : 1'b0;
                    n[c]++;
                end else begin
                    n[c] = 0;
                    pin[c] = 1'b0;
                end
            end
        end
    end

    initial begin : main
        // Patterns ch0..ch3; expected present and which channels raise an event.
        vecs[0].pat = '{8'h00, 8'hFF, 8'h00, 8'h00}; vecs[0].exp_present = 4'b0010; vecs[0].exp_evt_mask = 4'b0010;
        vecs[1].pat = '{8'h00, 8'hFF, 8'h00, 8'h00}; vecs[1].exp_present = 4'b0010; vecs[1].exp_evt_mask = 4'b0000;
        vecs[2].pat = '{8'h1F, 8'hFF, 8'h00, 8'h00}; vecs[2].exp_present = 4'b0011; vecs[2].exp_evt_mask = 4'b0001;
        vecs[3].pat = '{8'h0F, 8'hFF, 8'h00, 8'h00}; vecs[3].exp_present = 4'b0011; vecs[3].exp_evt_mask = 4'b0000;
        vecs[4].pat = '{8'h07, 8'hFF, 8'h00, 8'h00}; vecs[4].exp_present = 4'b0010; vecs[4].exp_evt_mask = 4'b0001;
        vecs[5].pat = '{8'h00, 8'h55, 8'h00, 8'h3F}; vecs[5].exp_present = 4'b1010; vecs[5].exp_evt_mask = 4'b1000;
        vecs[6].pat = '{8'h00, 8'h0B, 8'hFF, 8'hAA}; vecs[6].exp_present = 4'b1100; vecs[6].exp_evt_mask = 4'b0110;

        repeat (3) tick();
        check("reset_state", dbg_state, ST_IDLE);
        check("reset_outputs", {sensor_en, evt_valid, evt_ch, evt_present, present, busy}, 0);
        check("reset_ch", dbg_ch, 0);
        rst = 1'b0;
        tick();
        check("idle_no_start", {busy, sensor_en}, 0);

        load_round(0);
        start = 1'b1;
        for (int i = 0; i < NVEC; i++) begin
            wait_state(ST_WAIT_PERIOD, 300, $sformatf("round%0d_end", i));
            check($sformatf("round%0d_present", i), present, vecs[i].exp_present);
            check($sformatf("round%0d_events_left", i), exp_q.size(), 0);
            if (i < NVEC - 1) begin
                load_round(i + 1);
                while (dbg_state == ST_WAIT_PERIOD) tick();
            end
        end

        // Back-pressure: ch0 rises and is held in REPORT for 10 cycles.
        sens_pat = '{8'hFF, 8'h00, 8'h00, 8'h00};
        exp_q.push_back({2'd0, 1'b1});
        exp_q.push_back({2'd2, 1'b0});
        exp_q.push_back({2'd3, 1'b0});
        evt_ready = 1'b0;
        wait_evt_valid(300, "bp_evt_valid");
        for (int k = 0; k < 10; k++) begin
            check($sformatf("bp_hold%0d", k), {evt_valid, evt_ch, evt_present, sensor_en}, {1'b1, 2'd0, 1'b1, 4'b0000});
            check($sformatf("bp_state%0d", k), dbg_state, ST_REPORT);
            tick();
        end
        evt_ready = 1'b1;
        tick();
        check("bp_next_state", dbg_state, ST_SETTLE);
        check("bp_next_en", sensor_en, 4'b0010);

        // Stop during ch2 SAMPLE: round still finishes, ch3 event included.
        begin
            int k = 0;
            while (!(dbg_state == ST_SAMPLE && sensor_en == 4'b0100) && k < 200) begin
                tick();
                k++;
            end
        end
        check("stop_at_ch2_sample", {dbg_state == ST_SAMPLE, sensor_en}, {1'b1, 4'b0100});
        start = 1'b0;
        wait_state(ST_WAIT_PERIOD, 200, "stop_reach_wait");
        check("stop_ch_wrap", dbg_ch, 0);
        check("stop_present", present, 4'b0001);
        check("stop_events_left", exp_q.size(), 0);
        tick();
        check("stop_idle", dbg_state, ST_IDLE);
        check("stop_busy", {busy, sensor_en}, 0);

        // Reset while a ch0 falling event is stalled.
        sens_pat = '{8'h00, 8'h00, 8'h00, 8'h00};
        evt_ready = 1'b0;
        start = 1'b1;
        wait_evt_valid(200, "rst_evt_valid");
        check("rst_evt_fields", {evt_ch, evt_present}, {2'd0, 1'b0});
        rst = 1'b1;
        start = 1'b0;
        tick();
        check("rst_evt_dropped", evt_valid, 0);
        check("rst_present", present, 0);
        check("rst_state", dbg_state, ST_IDLE);
        check("rst_busy", {busy, sensor_en}, 0);
        rst = 1'b0;
        evt_ready = 1'b1;
        repeat (3) tick();

        check("sensor_en_rule_violations", onehot_viol, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/proximity_scan_ctrl.md
PROXIMITY_SCAN_CTRL -- requirements
Module: proximity_scan_ctrl

Interface
REQ-001 Parameter NUM_CH, default 4: number of proximity sensor channels scanned (2..8).
REQ-002 Parameter SETTLE_CYC, default 16: clk cycles between a channel's enable rising and its first sample.
REQ-003 Parameter SAMPLES, default 8: samples per channel per round; SHALL be a power of two, at least 2.
REQ-004 Parameter PERIOD_CYC, default 12000: idle clk cycles between the end of one round and the start of the next.
REQ-005 clk  input  1  single system clock; every flop SHALL be on its rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 start  input  1  level; while high, scan rounds repeat.
REQ-008 pin  input  NUM_CH  raw sensor outputs; asynchronous to clk.
REQ-009 sensor_en  output  NUM_CH  one-hot-or-zero enable to the sensor drivers.
REQ-010 evt_valid  output  1  change event available.
REQ-011 evt_ready  input  1  consumer accepts the event.
REQ-012 evt_ch  output  clog2(NUM_CH)  channel index of the event.
REQ-013 evt_present  output  1  new debounced state of evt_ch.
REQ-014 present  output  NUM_CH  debounced presence state per channel.
REQ-015 busy  output  1  high in every state except IDLE.

Function
REQ-016 Each pin bit SHALL pass through a 2-flop synchronizer before use; synchronizer latency: 2 cycles.
REQ-017 FSM states: IDLE, WAIT_PERIOD, SETTLE, SAMPLE, DECIDE, REPORT.
REQ-018 IDLE: when start=1, go to SETTLE with ch=0 on the next cycle.
REQ-019 SETTLE: sensor_en[ch]=1; count SETTLE_CYC cycles, then go to SAMPLE.
REQ-020 SAMPLE: sensor_en[ch]=1; take one sample per cycle for SAMPLES cycles; count the ones in a counter of width clog2(SAMPLES)+1.
REQ-021 DECIDE (1 cycle, sensor_en=0): new state = ones > SAMPLES/2; ones == SAMPLES/2 keeps the previous present[ch] (tie = hold).
REQ-022 If the new state differs from present[ch]: update present[ch] in the same cycle and go to REPORT. Otherwise skip REPORT.
REQ-023 REPORT: evt_valid=1; evt_ch and evt_present SHALL stay stable until the cycle with evt_valid & evt_ready. Transfer completes in that cycle and the FSM advances.
REQ-024 Back-pressure: while REPORT is stalled, no further channel is enabled or sampled.
REQ-025 Advance: if ch < NUM_CH-1, increment ch and go to SETTLE; if ch == NUM_CH-1, wrap ch to 0 and go to WAIT_PERIOD.
REQ-026 WAIT_PERIOD: count PERIOD_CYC cycles, then go to SETTLE if start=1, else IDLE. start=0 during WAIT_PERIOD SHALL return to IDLE immediately.
REQ-027 start=0 mid-round (SETTLE/SAMPLE/DECIDE/REPORT) SHALL NOT abort the round; the round completes, including any pending event.
REQ-028 At most one sensor_en bit SHALL be high in any cycle; sensor_en SHALL be 0 in IDLE, WAIT_PERIOD, DECIDE and REPORT.
REQ-029 Counters SHALL be sized from their parameters and SHALL NOT wrap within a state.

Reset
REQ-030 On rst=1: state=IDLE, ch=0, all counters 0, synchronizers 0, sensor_en=0, evt_valid=0, evt_ch=0, evt_present=0, present=0, busy=0.
REQ-031 rst asserted mid-operation, including during a stalled REPORT, SHALL drop the pending event without a handshake and take effect on the next edge.

Structure
REQ-032 A shared package proximity_pkg SHALL hold the state enumeration and the default values of SETTLE_CYC, SAMPLES and PERIOD_CYC.
REQ-033 The 2-flop synchronizer SHALL be a separate sub-module, sync2, instantiated once per channel; all other logic stays in proximity_scan_ctrl.

Verification (NUM_CH=4, SETTLE_CYC=4, SAMPLES=8, PERIOD_CYC=20)
REQ-034 Basic change: start=1, pin=4'b0010 steady, evt_ready=1 -> exactly one event (evt_ch=1, evt_present=1) in round 1; present=4'b0010; no events in round 2.
REQ-035 Majority and tie: ch0 sampled as 5 ones -> present[0]=1; next round 4 ones -> present[0] stays 1 with no event; then 3 ones -> event with evt_present=0.
REQ-036 Back-pressure: evt_ready=0 for 10 cycles while an event is pending -> evt_valid, evt_ch and evt_present are constant for all 10 cycles, sensor_en=0, and the next channel does not start until the handshake.
REQ-037 Stop and wrap: drop start during ch2 SAMPLE -> ch2 and ch3 complete, ch wraps to 0, WAIT_PERIOD exits to IDLE, busy=0.
REQ-038 Reset mid-REPORT: pulse rst while evt_valid=1 -> next cycle evt_valid=0, present=0 and state IDLE.
REQ-039 Continuous assertion: $onehot0(sensor_en) in every cycle, and sensor_en=0 outside SETTLE/SAMPLE.
